// File: rtl/cluster_pkg.sv
// ============================================================
// Package : cluster_pkg
// Brief   : Shared opcodes, instruction field positions and FSM states
// Rev     : 1.0
// ============================================================
`default_nettype none

package cluster_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_RD  = 3'b110;
  localparam logic [2:0] OP_RED = 3'b111;

  localparam int OP_HI     = 15;
  localparam int OP_LO     = 13;
  localparam int BCAST_BIT = 12;
  localparam int UNIT_HI   = 11;
  localparam int UNIT_LO   = 10;
  localparam int RD_HI     = 9;
  localparam int RD_LO     = 8;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;
  localparam int RS_HI     = 1;
  localparam int RS_LO     = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cluster_unit.sv
// ============================================================
// Module : cluster_unit
// Brief  : One compute unit: 4-entry register file, ALU, async read port
// Rev    : 1.0
// ============================================================
`default_nettype none

module cluster_unit
  import cluster_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        op,
  input  logic [1:0]        rd,
  input  logic [1:0]        rs,
  input  logic [7:0]        imm8,
  input  logic [1:0]        rsel,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_regs [4];
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_result;

  assign w_a = r_regs[rd];
  assign w_b = r_regs[rs];

  always_comb begin
    w_result = w_a;
    case (op)
      OP_LDI:  w_result = DATA_W'(imm8);
      OP_ADD:  w_result = w_a + w_b;
      OP_SUB:  w_result = w_a - w_b;
      OP_XOR:  w_result = w_a ^ w_b;
      OP_OR:   w_result = w_a | w_b;
      default: w_result = w_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (we) begin
      r_regs[rd] <= w_result;
    end
  end

  assign rdata = r_regs[rsel];

endmodule

`default_nettype wire

// File: rtl/compute_cluster.sv
// ============================================================
// Module : compute_cluster
// Brief  : NUM_UNITS ALU units behind one instruction port, registered result port
// Rev    : 1.0
// ============================================================
`default_nettype none

module compute_cluster
  import cluster_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_unit,
  output logic               out_red,
  output logic               busy,
  output logic               err
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_unit;
  logic              r_out_red;
  logic              r_err;
  logic [1:0]        r_idx;
  logic [1:0]        r_emit_rd;

  logic [2:0]        w_op;
  logic              w_bcast;
  logic [1:0]        w_unit;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs;
  logic [7:0]        w_imm;
  logic              w_accept;
  logic              w_unit_ok;
  logic              w_is_write;
  logic              w_bad;
  logic              w_out_fire;
  logic              w_last;
  logic [1:0]        w_next_idx;
  logic [1:0]        w_rsel;
  logic [DATA_W-1:0] w_red;
  logic [DATA_W-1:0] w_rd_data [4];

  assign w_op    = in_instr[OP_HI:OP_LO];
  assign w_bcast = in_instr[BCAST_BIT];
  assign w_unit  = in_instr[UNIT_HI:UNIT_LO];
  assign w_rd    = in_instr[RD_HI:RD_LO];
  assign w_rs    = in_instr[RS_HI:RS_LO];
  assign w_imm   = in_instr[IMM_HI:IMM_LO];

  assign in_ready   = ena & (r_state == ST_IDLE) & ~r_out_valid;
  assign w_accept   = in_valid & in_ready;
  assign w_unit_ok  = ({1'b0, w_unit} < 3'(NUM_UNITS));
  assign w_is_write = (w_op >= OP_LDI) && (w_op <= OP_OR);
  // Targeted ops naming a missing unit are swallowed and only flag err.
  assign w_bad      = w_accept & (w_is_write | (w_op == OP_RD)) & ~w_bcast & ~w_unit_ok;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_last     = (r_idx == 2'(NUM_UNITS - 1));
  assign w_next_idx = r_idx + 2'd1;
  assign w_rsel     = (r_state == ST_EMIT) ? r_emit_rd : w_rd;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    if (gi < NUM_UNITS) begin : g_unit
      logic w_we;
      assign w_we = w_accept & w_is_write & (w_bcast | (w_unit_ok & (w_unit == 2'(gi))));
      cluster_unit #(.DATA_W(DATA_W)) u_unit (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .op    (w_op),
        .rd    (w_rd),
        .rs    (w_rs),
        .imm8  (w_imm),
        .rsel  (w_rsel),
        .rdata (w_rd_data[gi])
      );
    end else begin : g_pad
      assign w_rd_data[gi] = '0;
    end
  end

  always_comb begin
    w_red = '0;
    for (int i = 0; i < NUM_UNITS; i++) w_red = w_red ^ w_rd_data[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && (w_op == OP_RD) && w_bcast) w_state_next = ST_EMIT;
      ST_EMIT: if (w_out_fire && w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_unit  <= '0;
      r_out_red   <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_emit_rd   <= '0;
    end else begin
      if (w_bad) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (w_op == OP_RD) && (w_bcast || w_unit_ok)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_bcast ? w_rd_data[0] : w_rd_data[w_unit];
            r_out_unit  <= w_bcast ? 2'd0 : w_unit;
            r_out_red   <= 1'b0;
            r_idx       <= 2'd0;
            r_emit_rd   <= w_rd;
          end else if (w_accept && (w_op == OP_RED)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_red;
            r_out_unit  <= 2'd0;
            r_out_red   <= 1'b1;
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (w_out_fire && w_last) begin
            r_out_valid <= 1'b0;
          end else if (!r_out_valid || out_ready) begin
            // Slot is free: load the next unit, or go empty while paused.
            if (ena) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_rd_data[w_next_idx];
              r_out_unit  <= w_next_idx;
              r_idx       <= w_next_idx;
            end else begin
              r_out_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_unit  = r_out_unit;
  assign out_red   = r_out_red;
  assign err       = r_err;
  assign busy      = (r_state != ST_IDLE) | r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_compute_cluster.sv
// ============================================================
// Module : tb_compute_cluster
// Brief  : Self-checking bench: result-queue model for a 4-unit cluster, directed 3-unit case
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_compute_cluster;
  import cluster_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, ena, in_valid, in_ready, out_valid, out_ready, out_red, busy, err;
  logic [15:0]  in_instr;
  logic [W-1:0] out_data;
  logic [1:0]   out_unit;

  logic         rst3_n, in_valid3, in_ready3, out_valid3, out_ready3, out_red3, busy3, err3;
  logic [15:0]  in_instr3;
  logic [W-1:0] out_data3;
  logic [1:0]   out_unit3;

  compute_cluster #(.NUM_UNITS(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_unit(out_unit), .out_red(out_red), .busy(busy), .err(err)
  );

  compute_cluster #(.NUM_UNITS(3), .DATA_W(W)) dut3 (
    .clk(clk), .rst_n(rst3_n), .ena(1'b1), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_instr(in_instr3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_unit(out_unit3), .out_red(out_red3), .busy(busy3), .err(err3)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] unit;
    logic       red;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] m_regs [N][4];
  res_t m_q[$];
  res_t log_q[$];
  res_t log3[$];
  bit   m_err = 1'b0;
  bit   mon_en = 1'b0;
  bit   prev_ena = 1'b1;

  function automatic logic [15:0] ins(input logic [2:0] op, input logic b, input logic [1:0] u,
                                      input logic [1:0] rd, input logic [7:0] imm);
    return {op, b, u, rd, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Architectural model: register contents plus the queue of results still owed.
  function automatic void apply(input logic [15:0] i);
    logic [2:0] op;
    logic       bc;
    int         u, rd, rs, lo, hi;
    logic [7:0] a, b, v, x;
    res_t       e;
    op = i[15:13]; bc = i[12]; u = int'(i[11:10]); rd = int'(i[9:8]); rs = int'(i[1:0]);
    if (op == OP_NOP) return;
    if (op == OP_RED) begin
      x = 8'h00;
      for (int k = 0; k < N; k++) x = x ^ m_regs[k][rd];
      e = {x, 2'd0, 1'b1};
      m_q.push_back(e);
      return;
    end
    if (!bc && u >= N) begin
      m_err = 1'b1;
      return;
    end
    lo = bc ? 0 : u;
    hi = bc ? N - 1 : u;
    for (int k = lo; k <= hi; k++) begin
      a = m_regs[k][rd];
      b = m_regs[k][rs];
      case (op)
        OP_LDI:  v = i[7:0];
        OP_ADD:  v = a + b;
        OP_SUB:  v = a - b;
        OP_XOR:  v = a ^ b;
        OP_OR:   v = a | b;
        default: v = a;
      endcase
      if (op == OP_RD) begin
        e = {a, 2'(k), 1'b0};
        m_q.push_back(e);
      end else begin
        m_regs[k][rd] = v;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, ena && m_q.size() == 0);
      chk("err", err, m_err);
      chk("busy", busy, m_q.size() != 0);
      if (m_q.size() == 0) chk("out_valid idle", out_valid, 0);
      else if (prev_ena) chk("out_valid", out_valid, 1);
      if (out_valid && m_q.size() != 0) begin
        chk("out_data", out_data, m_q[0].data);
        chk("out_unit", out_unit, m_q[0].unit);
        chk("out_red", out_red, m_q[0].red);
      end
      if (out_valid && out_ready) begin
        log_q.push_back({out_data, out_unit, out_red});
        if (m_q.size() != 0) void'(m_q.pop_front());
      end
      if (in_valid && ena && m_q.size() == 0) apply(in_instr);
      prev_ena = ena;
    end
  end

  always @(negedge clk) begin
    if (out_valid3 && out_ready3) log3.push_back({out_data3, out_unit3, out_red3});
  end

  task automatic send(input logic [15:0] i);
    int n;
    n = 0;
    in_instr = i;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send3(input logic [15:0] i);
    int n;
    n = 0;
    in_instr3 = i;
    in_valid3 = 1'b1;
    @(negedge clk);
    while (!in_ready3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send3 timeout", in_ready3, 1);
    @(posedge clk);
    #1 in_valid3 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    if (n >= 100) chk("drain timeout", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [7:0] d,
                         input logic [1:0] u, input logic r);
    res_t e;
    e = {d, u, r};
    if (idx >= log_q.size()) chk({name, " missing"}, log_q.size(), idx + 1);
    else chk(name, 32'(log_q[idx]), 32'(e));
  endtask

  initial begin
    int base;
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    for (int u = 0; u < N; u++) for (int r = 0; r < 4; r++) m_regs[u][r] = '0;
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    rst3_n = 1'b0; in_valid3 = 1'b0; in_instr3 = '0; out_ready3 = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_unit", out_unit, 0);
    chk("rst out_red", out_red, 0);
    chk("rst err", err, 0);
    chk("rst busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // LDI then back-to-back RD, latency 1
    base = log_q.size();
    send(ins(OP_LDI, 0, 2'd1, 2'd0, 8'h5A));
    send(ins(OP_RD, 0, 2'd1, 2'd0, 8'h00));
    chk("rd latency", out_valid, 1);
    drain();
    chk_log("rd u1", base, 8'h5A, 2'd1, 1'b0);

    // Broadcast write, targeted add, broadcast read with backpressure
    base = log_q.size();
    send(ins(OP_LDI, 1, 2'd0, 2'd2, 8'h10));
    send(ins(OP_LDI, 0, 2'd2, 2'd1, 8'h05));
    send(ins(OP_ADD, 0, 2'd2, 2'd2, 8'h01));
    send(ins(OP_RD, 1, 2'd3, 2'd2, 8'h00));
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    chk_log("emit u0", base, 8'h10, 2'd0, 1'b0);
    chk_log("emit u1", base + 1, 8'h10, 2'd1, 1'b0);
    chk_log("emit u2", base + 2, 8'h15, 2'd2, 1'b0);
    chk_log("emit u3", base + 3, 8'h10, 2'd3, 1'b0);
    chk("emit count", log_q.size() - base, 4);
    chk("in_ready after emit", in_ready, 1);

    // SUB wrap
    base = log_q.size();
    send(ins(OP_LDI, 0, 2'd0, 2'd0, 8'h03));
    send(ins(OP_LDI, 0, 2'd0, 2'd1, 8'h05));
    send(ins(OP_SUB, 0, 2'd0, 2'd0, 8'h01));
    send(ins(OP_RD, 0, 2'd0, 2'd0, 8'h00));
    drain();
    chk_log("sub wrap", base, 8'hFE, 2'd0, 1'b0);

    // XOR then OR
    base = log_q.size();
    send(ins(OP_LDI, 0, 2'd3, 2'd0, 8'h0F));
    send(ins(OP_LDI, 0, 2'd3, 2'd1, 8'h3C));
    send(ins(OP_XOR, 0, 2'd3, 2'd0, 8'h01));
    send(ins(OP_RD, 0, 2'd3, 2'd0, 8'h00));
    drain();
    send(ins(OP_NOP, 0, 2'd3, 2'd0, 8'hFF));
    send(ins(OP_OR, 0, 2'd3, 2'd0, 8'h01));
    send(ins(OP_RD, 0, 2'd3, 2'd0, 8'h00));
    drain();
    chk_log("xor", base, 8'h33, 2'd3, 1'b0);
    chk_log("or", base + 1, 8'h3F, 2'd3, 1'b0);

    // RED with the result held under backpressure
    base = log_q.size();
    send(ins(OP_LDI, 0, 2'd0, 2'd3, 8'h01));
    send(ins(OP_LDI, 0, 2'd1, 2'd3, 8'h02));
    send(ins(OP_LDI, 0, 2'd2, 2'd3, 8'h04));
    send(ins(OP_LDI, 0, 2'd3, 2'd3, 8'h80));
    out_ready = 1'b0;
    send(ins(OP_RED, 1, 2'd2, 2'd3, 8'h00));
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    chk_log("red", base, 8'h87, 2'd0, 1'b1);

    // Broadcast read paused by ena
    base = log_q.size();
    send(ins(OP_RD, 1, 2'd0, 2'd3, 8'h00));
    @(posedge clk);
    #1 ena = 1'b0;
    repeat (4) @(posedge clk);
    #1 ena = 1'b1;
    drain();
    chk_log("pause u0", base, 8'h01, 2'd0, 1'b0);
    chk_log("pause u1", base + 1, 8'h02, 2'd1, 1'b0);
    chk_log("pause u2", base + 2, 8'h04, 2'd2, 1'b0);
    chk_log("pause u3", base + 3, 8'h80, 2'd3, 1'b0);

    // Three-unit cluster: out-of-range target, then reset during EMIT
    @(posedge clk);
    #1 rst3_n = 1'b1;
    send3(ins(OP_LDI, 1, 2'd0, 2'd0, 8'h11));
    send3(ins(OP_LDI, 0, 2'd3, 2'd0, 8'hFF));
    chk("n3 err", err3, 1);
    send3(ins(OP_RD, 1, 2'd0, 2'd0, 8'h00));
    n = 0;
    while (busy3 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("n3 emit count", log3.size(), 3);
    for (int k = 0; k < 3 && k < log3.size(); k++)
      chk("n3 emit", 32'(log3[k]), 32'({8'h11, 2'(k), 1'b0}));
    out_ready3 = 1'b0;
    send3(ins(OP_RD, 1, 2'd0, 2'd0, 8'h00));
    out_ready3 = 1'b1;
    @(posedge clk);
    #1 rst3_n = 1'b0;
    out_ready3 = 1'b0;
    @(negedge clk);
    chk("n3 mid-emit valid before reset edge", out_valid3, 1);
    @(negedge clk);
    chk("n3 reset out_valid", out_valid3, 0);
    chk("n3 reset busy", busy3, 0);
    chk("n3 reset err", err3, 0);
    @(posedge clk);
    #1 rst3_n = 1'b1;
    out_ready3 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("n3 no further results", log3.size(), 4);
    if (log3.size() > 3) chk("n3 first before reset", 32'(log3[3]), 32'({8'h11, 2'd0, 1'b0}));
    chk("n3 in_ready", in_ready3, 1);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
